// File: rtl/fir_sym_mc.sv
// Multi-channel symmetric FIR. Per-channel delay lines feed one shared pre-add/MAC
// datapath, with round-half-up, saturation and an optional per-channel decimate-by-2.
module fir_sym_mc #(
  parameter int DW = 10,
  parameter int CW = 10,
  parameter int FW = 7,
  parameter int CH = 2,
  parameter int SL = 7,
  localparam int FN  = (FW + 1) / 2,
  localparam int CHW = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic                 Clk,
  input  logic                 Rstn,
  input  logic                 Clear,
  input  logic signed [DW-1:0] DataIn,
  input  logic [CHW-1:0]       DataInCh,
  input  logic                 DataInVld,
  output logic                 DataInRdy,
  input  logic                 DecEn,
  input  logic [CH*FN*CW-1:0]  Coeff,
  output logic signed [DW-1:0] DataOut,
  output logic [CHW-1:0]       DataOutCh,
  output logic                 DataOutVld
);
  localparam int KW = (FN > 1) ? $clog2(FN) : 1;
  localparam int AW = DW + CW + $clog2(FN) + 2;
  localparam int PW = DW + CW + 1;
  localparam logic signed [AW-1:0] RND     = AW'(1) << (SL - 1);
  localparam logic signed [AW-1:0] SAT_MAX = AW'((1 << (DW - 1)) - 1);
  localparam logic signed [AW-1:0] SAT_MIN = ~SAT_MAX;

  typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

  state_t               r_state, w_next;
  logic signed [DW-1:0] r_dly [CH][FW];
  logic [CH-1:0]        r_ph;
  logic [CHW-1:0]       r_ch;
  logic [KW-1:0]        r_k;
  logic signed [AW-1:0] r_acc;

  logic                 w_flush, w_accept, w_chOk, w_trig, w_lastTap;
  logic [31:0]          w_chExt;
  logic signed [DW-1:0] w_lo, w_hi;
  logic signed [DW:0]   w_pre;
  logic signed [CW-1:0] w_coef;
  logic signed [PW-1:0] w_prod;
  logic signed [AW-1:0] w_rnd;
  logic signed [DW-1:0] w_sat;

  assign w_flush   = !Rstn || Clear;
  assign DataInRdy = (r_state == IDLE) && !Clear && Rstn;
  assign w_accept  = DataInVld && DataInRdy;
  assign w_chExt   = 32'(DataInCh);
  assign w_chOk    = w_chExt < 32'(CH);
  // With decimation on, only the second sample of each pair per channel computes.
  assign w_trig    = w_accept && w_chOk && (!DecEn || r_ph[DataInCh]);
  assign w_lastTap = (r_k == KW'(FN - 1));

  always_ff @(posedge Clk) begin
    if (w_flush) r_state <= IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_trig) w_next = MAC;
      MAC:     if (w_lastTap) w_next = OUT;
      OUT:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Tap k pairs d[k] with its mirror d[FW-1-k]; the centre tap stands alone.
  always_comb begin : macTerm
    int tapLo;
    tapLo  = int'(r_k);
    w_lo   = r_dly[r_ch][tapLo];
    w_hi   = r_dly[r_ch][FW - 1 - tapLo];
    w_coef = $signed(Coeff[(int'(r_ch) * FN + tapLo) * CW +: CW]);
    if (w_lastTap) w_pre = {w_lo[DW-1], w_lo};
    else           w_pre = {w_lo[DW-1], w_lo} + {w_hi[DW-1], w_hi};
    w_prod = PW'(w_coef) * PW'(w_pre);
  end

  always_comb begin
    w_rnd = (r_acc + RND) >>> SL;
    if (w_rnd > SAT_MAX)      w_sat = SAT_MAX[DW-1:0];
    else if (w_rnd < SAT_MIN) w_sat = SAT_MIN[DW-1:0];
    else                      w_sat = w_rnd[DW-1:0];
  end

  always_ff @(posedge Clk) begin
    if (w_flush) begin
      for (int c = 0; c < CH; c++)
        for (int i = 0; i < FW; i++) r_dly[c][i] <= '0;
      r_ph       <= '0;
      r_ch       <= '0;
      r_k        <= '0;
      r_acc      <= '0;
      DataOut    <= '0;
      DataOutCh  <= '0;
      DataOutVld <= 1'b0;
    end else begin
      DataOutVld <= 1'b0;
      if (w_accept && w_chOk) begin
        for (int c = 0; c < CH; c++) begin
          if (DataInCh == CHW'(c)) begin
            r_dly[c][0] <= DataIn;
            for (int i = 1; i < FW; i++) r_dly[c][i] <= r_dly[c][i-1];
            r_ph[c] <= ~r_ph[c];
          end
        end
        r_ch  <= DataInCh;
        r_k   <= '0;
        r_acc <= '0;
      end
      if (r_state == MAC) begin
        r_acc <= r_acc + AW'(w_prod);
        r_k   <= r_k + KW'(1);
      end
      if (r_state == OUT) begin
        DataOut    <= w_sat;
        DataOutCh  <= r_ch;
        DataOutVld <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_fir_sym_mc.sv
// Directed bench for fir_sym_mc: default instance for the filter scenarios, plus a
// three-channel instance so an out-of-range channel code can actually be driven.
module tb_fir_sym_mc;
  logic Clk = 1'b0;
  always #5 Clk = ~Clk;

  logic              Rstn, Clear, DataInVld, DecEn, DataInRdy, DataOutVld;
  logic signed [9:0] DataIn, DataOut;
  logic [0:0]        DataInCh, DataOutCh;
  logic [79:0]       Coeff;

  logic              vld3, rdy3, vld3Out;
  logic signed [9:0] in3, out3;
  logic [1:0]        ch3, outCh3;
  logic [119:0]      coeff3;

  int nChecks = 0;
  int nPass   = 0;

  fir_sym_mc u_dut (
    .Clk(Clk), .Rstn(Rstn), .Clear(Clear), .DataIn(DataIn), .DataInCh(DataInCh),
    .DataInVld(DataInVld), .DataInRdy(DataInRdy), .DecEn(DecEn), .Coeff(Coeff),
    .DataOut(DataOut), .DataOutCh(DataOutCh), .DataOutVld(DataOutVld)
  );

  fir_sym_mc #(.CH(3)) u_dut3 (
    .Clk(Clk), .Rstn(Rstn), .Clear(Clear), .DataIn(in3), .DataInCh(ch3),
    .DataInVld(vld3), .DataInRdy(rdy3), .DecEn(1'b0), .Coeff(coeff3),
    .DataOut(out3), .DataOutCh(outCh3), .DataOutVld(vld3Out)
  );

  task automatic setTaps(input int ch, input int t0, input int t1, input int t2, input int t3);
    Coeff[(ch*4+0)*10 +: 10] = 10'(t0);
    Coeff[(ch*4+1)*10 +: 10] = 10'(t1);
    Coeff[(ch*4+2)*10 +: 10] = 10'(t2);
    Coeff[(ch*4+3)*10 +: 10] = 10'(t3);
  endtask

  task automatic doClear();
    Clear = 1'b1;
    @(posedge Clk); #1;
    Clear = 1'b0;
  endtask

  // Accepts one sample from IDLE and watches up to maxWait cycles for the result.
  // lat is the cycle offset of DataOutVld after the accept edge, or 0 if no pulse arrived.
  task automatic runSample(input int ch, input int data, input logic dec, input int maxWait,
                           output int lat, output logic signed [9:0] val, output logic [0:0] och,
                           output int rdyLow, output logic rdy1);
    DataInCh  = 1'(ch);
    DataIn    = 10'(data);
    DecEn     = dec;
    DataInVld = 1'b1;
    @(posedge Clk); #1;
    DataInVld = 1'b0;
    lat = 0; rdyLow = 0; val = '0; och = '0;
    rdy1 = DataInRdy;
    for (int n = 1; n <= maxWait; n++) begin
      if (DataOutVld) begin
        lat = n; val = DataOut; och = DataOutCh;
        break;
      end
      if (!DataInRdy) rdyLow++;
      @(posedge Clk); #1;
    end
  endtask

  task automatic test_reset();
    Rstn = 1'b0; Clear = 1'b0; DataInVld = 1'b0; DecEn = 1'b0; DataIn = '0; DataInCh = '0;
    Coeff = '0; vld3 = 1'b0; in3 = '0; ch3 = '0; coeff3 = '0;
    @(posedge Clk); @(posedge Clk); #1;
    nChecks++;
    if (DataInRdy !== 1'b0) $display("[TB] FAIL reset_rdy got %0b expected 0", DataInRdy);
    else nPass++;
    nChecks++;
    if (DataOutVld !== 1'b0) $display("[TB] FAIL reset_vld got %0b expected 0", DataOutVld);
    else nPass++;
    nChecks++;
    if (DataOut !== 10'sd0) $display("[TB] FAIL reset_out got %0d expected 0", DataOut);
    else nPass++;
    nChecks++;
    if (DataOutCh !== 1'b0) $display("[TB] FAIL reset_och got %0d expected 0", DataOutCh);
    else nPass++;
    Rstn = 1'b1;
    #1;
    nChecks++;
    if (DataInRdy !== 1'b1) $display("[TB] FAIL reset_rdy_after got %0b expected 1", DataInRdy);
    else nPass++;
    @(posedge Clk); #1;
  endtask

  task automatic test_impulse();
    int expImp [7] = '{100, 0, 0, 0, 0, 0, 100};
    int lat, rl;
    logic signed [9:0] val;
    logic [0:0] och;
    logic r1;
    setTaps(0, 128, 0, 0, 0);
    setTaps(1, 0, 0, 0, 0);
    doClear();
    for (int i = 0; i < 7; i++) begin
      runSample(0, (i == 0) ? 100 : 0, 1'b0, 10, lat, val, och, rl, r1);
      nChecks++;
      if (val !== 10'(expImp[i])) $display("[TB] FAIL impulse_val[%0d] got %0d expected %0d", i, val, expImp[i]);
      else nPass++;
      nChecks++;
      if (lat !== 6) $display("[TB] FAIL impulse_latency[%0d] got %0d expected 6", i, lat);
      else nPass++;
      nChecks++;
      if (rl !== 5) $display("[TB] FAIL impulse_rdy_low[%0d] got %0d expected 5", i, rl);
      else nPass++;
    end
    @(posedge Clk); #1;
    nChecks++;
    if (DataOutVld !== 1'b0) $display("[TB] FAIL vld_one_cycle got %0b expected 0", DataOutVld);
    else nPass++;
    nChecks++;
    if (DataOut !== 10'sd100) $display("[TB] FAIL out_hold got %0d expected 100", DataOut);
    else nPass++;
  endtask

  task automatic test_rounding();
    int ins  [4] = '{64, 63, -64, -65};
    int exps [4] = '{1, 0, 0, -1};
    int lat, rl;
    logic signed [9:0] val;
    logic [0:0] och;
    logic r1;
    setTaps(0, 0, 0, 0, 1);
    doClear();
    for (int r = 0; r < 4; r++) begin
      for (int j = 0; j < 4; j++) begin
        runSample(0, (j == 0) ? ins[r] : 0, 1'b0, 10, lat, val, och, rl, r1);
        if (j == 3) begin
          nChecks++;
          if (val !== 10'(exps[r])) $display("[TB] FAIL round[%0d] got %0d expected %0d", ins[r], val, exps[r]);
          else nPass++;
        end
      end
    end
  endtask

  task automatic test_saturation();
    int lat, rl;
    logic signed [9:0] val;
    logic [0:0] och;
    logic r1;
    setTaps(0, 511, 511, 511, 511);
    doClear();
    for (int i = 0; i < 7; i++) runSample(0, 511, 1'b0, 10, lat, val, och, rl, r1);
    nChecks++;
    if (val !== 10'sd511) $display("[TB] FAIL sat_pos got %0d expected 511", val);
    else nPass++;
    for (int i = 0; i < 7; i++) runSample(0, -512, 1'b0, 10, lat, val, och, rl, r1);
    nChecks++;
    if (val !== -10'sd512) $display("[TB] FAIL sat_neg got %0d expected -512", val);
    else nPass++;
  endtask

  task automatic test_interleave();
    int lat, rl, expv;
    logic signed [9:0] val;
    logic [0:0] och;
    logic r1;
    setTaps(0, 128, 0, 0, 0);
    setTaps(1, 0, 0, 0, 128);
    doClear();
    for (int i = 0; i < 7; i++) begin
      for (int ch = 0; ch < 2; ch++) begin
        runSample(ch, (i == 0) ? ((ch == 0) ? 10 : 20) : 0, 1'b0, 10, lat, val, och, rl, r1);
        if (ch == 0) expv = (i == 0 || i == 6) ? 10 : 0;
        else         expv = (i == 3) ? 20 : 0;
        nChecks++;
        if (val !== 10'(expv)) $display("[TB] FAIL ilv_val ch%0d[%0d] got %0d expected %0d", ch, i, val, expv);
        else nPass++;
        nChecks++;
        if (och !== 1'(ch)) $display("[TB] FAIL ilv_och[%0d] got %0d expected %0d", i, och, ch);
        else nPass++;
      end
    end
  endtask

  task automatic test_decimation();
    int lat, rl, pulses, expv;
    logic signed [9:0] val;
    logic [0:0] och;
    logic r1;
    setTaps(0, 128, 0, 0, 0);
    setTaps(1, 0, 0, 0, 0);
    doClear();
    pulses = 0;
    for (int i = 1; i <= 8; i++) begin
      runSample(0, i, 1'b1, 8, lat, val, och, rl, r1);
      if (lat != 0) pulses++;
      if (i % 2 == 0) begin
        expv = (i == 8) ? 10 : i;
        nChecks++;
        if (lat !== 6) $display("[TB] FAIL dec_latency[%0d] got %0d expected 6", i, lat);
        else nPass++;
        nChecks++;
        if (val !== 10'(expv)) $display("[TB] FAIL dec_val[%0d] got %0d expected %0d", i, val, expv);
        else nPass++;
      end else begin
        nChecks++;
        if (r1 !== 1'b1) $display("[TB] FAIL dec_rdy_odd[%0d] got %0b expected 1", i, r1);
        else nPass++;
      end
    end
    nChecks++;
    if (pulses !== 4) $display("[TB] FAIL dec_pulses got %0d expected 4", pulses);
    else nPass++;
    DecEn = 1'b0;
  endtask

  task automatic test_clear_mid();
    int expImp [7] = '{77, 0, 0, 0, 0, 0, 77};
    int lat, rl, seen;
    logic signed [9:0] val;
    logic [0:0] och;
    logic r1;
    setTaps(0, 128, 0, 0, 0);
    doClear();
    DataInCh = 1'b0; DataIn = 10'sd50; DecEn = 1'b0; DataInVld = 1'b1;
    @(posedge Clk); #1;
    DataInVld = 1'b0;
    @(posedge Clk); #1;
    Clear = 1'b1;
    #1;
    nChecks++;
    if (DataInRdy !== 1'b0) $display("[TB] FAIL clear_rdy_during got %0b expected 0", DataInRdy);
    else nPass++;
    @(posedge Clk); #1;
    Clear = 1'b0;
    #1;
    nChecks++;
    if (DataInRdy !== 1'b1) $display("[TB] FAIL clear_rdy_after got %0b expected 1", DataInRdy);
    else nPass++;
    seen = 0;
    for (int n = 0; n < 10; n++) begin
      if (DataOutVld) seen++;
      @(posedge Clk); #1;
    end
    nChecks++;
    if (seen !== 0) $display("[TB] FAIL clear_no_output got %0d pulses expected 0", seen);
    else nPass++;
    for (int i = 0; i < 7; i++) begin
      runSample(0, (i == 0) ? 77 : 0, 1'b0, 10, lat, val, och, rl, r1);
      nChecks++;
      if (val !== 10'(expImp[i])) $display("[TB] FAIL clear_residue[%0d] got %0d expected %0d", i, val, expImp[i]);
      else nPass++;
    end
  endtask

  task automatic test_invalid_channel();
    int seen, lat;
    coeff3 = '0;
    coeff3[0 +: 10]          = 10'd128;
    coeff3[(2*4)*10 +: 10]   = 10'd128;
    ch3 = 2'd3; in3 = 10'sd99; vld3 = 1'b1;
    #1;
    nChecks++;
    if (rdy3 !== 1'b1) $display("[TB] FAIL badch_rdy_before got %0b expected 1", rdy3);
    else nPass++;
    @(posedge Clk); #1;
    vld3 = 1'b0;
    nChecks++;
    if (rdy3 !== 1'b1) $display("[TB] FAIL badch_rdy_after got %0b expected 1", rdy3);
    else nPass++;
    seen = 0;
    for (int n = 0; n < 8; n++) begin
      if (vld3Out) seen++;
      @(posedge Clk); #1;
    end
    nChecks++;
    if (seen !== 0) $display("[TB] FAIL badch_no_output got %0d pulses expected 0", seen);
    else nPass++;
    ch3 = 2'd2; in3 = 10'sd33; vld3 = 1'b1;
    @(posedge Clk); #1;
    vld3 = 1'b0;
    lat = 0;
    for (int n = 1; n <= 10; n++) begin
      if (vld3Out) begin lat = n; break; end
      @(posedge Clk); #1;
    end
    nChecks++;
    if (lat !== 6) $display("[TB] FAIL ch2_latency got %0d expected 6", lat);
    else nPass++;
    nChecks++;
    if (out3 !== 10'sd33) $display("[TB] FAIL ch2_val got %0d expected 33", out3);
    else nPass++;
    nChecks++;
    if (outCh3 !== 2'd2) $display("[TB] FAIL ch2_och got %0d expected 2", outCh3);
    else nPass++;
  endtask

  task automatic test_reset_during_out();
    int seen;
    setTaps(0, 128, 0, 0, 0);
    DataInCh = 1'b0; DataIn = 10'sd100; DecEn = 1'b0; DataInVld = 1'b1;
    @(posedge Clk); #1;
    DataInVld = 1'b0;
    for (int n = 0; n < 4; n++) begin
      @(posedge Clk); #1;
    end
    Rstn = 1'b0;
    #1;
    nChecks++;
    if (DataInRdy !== 1'b0) $display("[TB] FAIL rst_out_rdy_low got %0b expected 0", DataInRdy);
    else nPass++;
    @(posedge Clk); #1;
    Rstn = 1'b1;
    nChecks++;
    if (DataOutVld !== 1'b0) $display("[TB] FAIL rst_out_vld got %0b expected 0", DataOutVld);
    else nPass++;
    nChecks++;
    if (DataOut !== 10'sd0) $display("[TB] FAIL rst_out_val got %0d expected 0", DataOut);
    else nPass++;
    seen = 0;
    for (int n = 0; n < 8; n++) begin
      if (DataOutVld) seen++;
      @(posedge Clk); #1;
    end
    nChecks++;
    if (seen !== 0) $display("[TB] FAIL rst_out_no_pulse got %0d pulses expected 0", seen);
    else nPass++;
    nChecks++;
    if (DataInRdy !== 1'b1) $display("[TB] FAIL rst_out_rdy got %0b expected 1", DataInRdy);
    else nPass++;
  endtask

  initial begin
    test_reset();
    test_impulse();
    test_rounding();
    test_saturation();
    test_interleave();
    test_decimation();
    test_clear_mid();
    test_invalid_channel();
    test_reset_during_out();
    $display("[TB] %0d/%0d checks passed", nPass, nChecks);
    $finish;
  end
endmodule
